fluid_split_sequencer: RTL
==========================

Name: fluid_split_sequencer

Overview:
- Fan-out counterpart of the chamber/mixer reduction trees: one Source is dispensed into up to N_CHAMBERS downstream chambers, one chamber at a time.
- For each requested chamber the block opens that chamber's inlet valve, meters the fill for a fixed cycle count, then settles before moving to the next.
- Sits between the run controller (start handshake) and the pneumatic valve drivers / source pump.

Parameters:
- N_CHAMBERS, 8, number of chamber inlet valves; range 2..32.
- FILL_CYCLES, 16, pressurised cycles per chamber fill; must be >=1.
- SETTLE_CYCLES, 4, all-valves-closed cycles after each fill; must be >=1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start_valid  input  1  fill request valid.
- start_ready  output  1  block idle and accepting a request.
- chamber_mask  input  N_CHAMBERS  chambers to fill; sampled on handshake.
- pressure_ok  input  1  source pressure within range; metering pauses when low.
- abort  input  1  synchronous abort request.
- valve_en  output  N_CHAMBERS  one-hot inlet valve enables; all zero outside FILL.
- source_on  output  1  source pump enable.
- cur_idx  output  clog2(N_CHAMBERS)  index of the chamber being filled.
- filled_count  output  clog2(N_CHAMBERS+1)  chambers completed in the current run.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when a run completes normally.
- aborted  output  1  one-cycle pulse when a run is aborted.

Behaviour:
- States: IDLE, SCAN, FILL, SETTLE, DONE. All outputs are decoded from registered state (Moore). No combinational input-to-output paths.
- Reset (asynchronous, any cycle, including mid-fill):
  - State goes to IDLE. Pending mask, counters, cur_idx and filled_count clear to 0.
  - valve_en=0, source_on=0, done=0, aborted=0, busy=0, start_ready=1.
- IDLE:
  - start_ready=1.
  - On start_valid&start_ready: latch chamber_mask into pending, clear filled_count.
  - If mask==0, go to DONE. Otherwise go to SCAN.
  - start_valid is ignored whenever start_ready=0.
- SCAN (1 cycle):
  - cur_idx <= lowest set bit of pending.
  - Fill counter <= FILL_CYCLES-1; go to FILL.
- FILL:
  - valve_en = one-hot(cur_idx) for the whole state, including pressure-low cycles.
  - source_on = 1 only on cycles where the registered pressure_ok is 1. pressure_ok is registered once before use, so source_on reacts 1 cycle late.
  - Counter decrements only on cycles where the registered pressure_ok=1. Pressure-low cycles extend FILL 1:1.
  - When counter==0 and pressure is ok:
    - Clear pending[cur_idx], increment filled_count.
    - Settle counter <= SETTLE_CYCLES-1; go to SETTLE.
- SETTLE:
  - valve_en=0, source_on=0.
  - Counter decrements every cycle. At 0, go to SCAN if pending!=0, else go to DONE.
- DONE: done=1 for exactly 1 cycle, then IDLE. filled_count holds until the next accepted start.
- abort:
  - Highest priority in SCAN/FILL/SETTLE/DONE. Next state is IDLE and pending clears.
  - aborted=1 for the single cycle after abort is sampled, while already back in IDLE.
  - valve_en/source_on are 0 from that cycle. done is not asserted.
  - filled_count keeps completed chambers only; a partially filled chamber is not counted.
  - abort in IDLE has no effect.
- Simultaneous abort and the FILL terminal count: abort wins, and the chamber is not counted.
- Timing per chamber: 1 (SCAN) + FILL_CYCLES + SETTLE_CYCLES cycles, plus any pressure-low cycles.
  - Start accepted at cycle T: DONE is at T+1+k*(1+FILL_CYCLES+SETTLE_CYCLES) for k chambers.
- Fill order is always ascending chamber index.

Test Plan:
- Single chamber, default params:
  - Stimulus: mask=0x01, pressure_ok=1, start at T.
  - Required: valve_en=0x01 during T+2..T+17; SETTLE T+18..T+21; done=1 at T+22; filled_count=1; start_ready=1 at T+23.
- Multi-chamber order:
  - Stimulus: mask=0xA5.
  - Required: valve_en sequence 0x01, 0x04, 0x20, 0x80, each high for 16 cycles; never two bits high at once; done at T+85; filled_count=4.
- Pressure drop:
  - Stimulus: mask=0x02; pressure_ok low for 5 cycles starting 6 cycles into FILL.
  - Required: valve_en=0x02 stays high throughout; source_on low for 5 cycles (lagging by 1); FILL lasts 21 cycles; done at T+27.
- Abort mid-run:
  - Stimulus: mask=0x0F; abort during FILL of chamber 1.
  - Required: next cycle valve_en=0, source_on=0, aborted=1, state IDLE; no done; filled_count=1; a new start is accepted immediately after.
- Empty mask and busy request:
  - Stimulus: mask=0x00.
  - Required: done at T+1, filled_count=0, no valve activity.
  - Stimulus: start_valid held high during a run.
  - Required: no second acceptance until the run ends.
- Async reset:
  - Stimulus: rst_n low mid-FILL, between clock edges.
  - Required: valve_en and source_on drop immediately without waiting for a clock edge; all outputs at their reset values.

Source files
------------

// File: rtl/fluid_split_sequencer_if.sv
`timescale 1ns/1ps
// fluid_split_sequencer_if
// Start handshake between the run controller and the split sequencer.
//   start_valid  : controller -> sequencer, fill request valid
//   start_ready  : sequencer -> controller, sequencer idle and accepting
//   chamber_mask : controller -> sequencer, chambers to fill, sampled on handshake
// The master modport is the run controller, the slave modport is the sequencer.
interface fluid_split_sequencer_if #(
    parameter int N_CHAMBERS = 8
);
    logic                  start_valid;
    logic                  start_ready;
    logic [N_CHAMBERS-1:0] chamber_mask;

    modport master (
        output start_valid,
        output chamber_mask,
        input  start_ready
    );

    modport slave (
        input  start_valid,
        input  chamber_mask,
        output start_ready
    );
endinterface

// File: rtl/fluid_split_sequencer.sv
`timescale 1ns/1ps
// fluid_split_sequencer
// Dispenses one fluid source into up to N_CHAMBERS chambers, one at a time in
// ascending index order. Each chamber gets a SCAN cycle, FILL_CYCLES metered
// (pressure-ok) cycles with its inlet valve open, then SETTLE_CYCLES with all
// valves closed. All outputs are decoded from registers (Moore).
// Ports:
//   clk, rst_n    : clock (rising edge), asynchronous active-low reset
//   start_if      : slave side of the start handshake (valid/ready/mask)
//   pressure_ok   : source pressure in range; metering pauses while low
//   abort         : synchronous abort of a run in progress
//   valve_en      : one-hot inlet valve enables, only during FILL
//   source_on     : source pump enable
//   cur_idx       : chamber currently being filled
//   filled_count  : chambers completed in the current run
//   busy          : high whenever not idle
//   done, aborted : one-cycle completion / abort pulses
module fluid_split_sequencer #(
    parameter int N_CHAMBERS    = 8,
    parameter int FILL_CYCLES   = 16,
    parameter int SETTLE_CYCLES = 4,
    localparam int IDX_W = $clog2(N_CHAMBERS),
    localparam int CNT_W = $clog2(N_CHAMBERS + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    fluid_split_sequencer_if.slave start_if,
    input  logic                  pressure_ok,
    input  logic                  abort,
    output logic [N_CHAMBERS-1:0] valve_en,
    output logic                  source_on,
    output logic [IDX_W-1:0]      cur_idx,
    output logic [CNT_W-1:0]      filled_count,
    output logic                  busy,
    output logic                  done,
    output logic                  aborted
);

    // One timer serves both FILL and SETTLE, so it is sized for the longer one.
    localparam int MAX_CYC = (FILL_CYCLES > SETTLE_CYCLES) ? FILL_CYCLES : SETTLE_CYCLES;
    localparam int TMR_W   = $clog2(MAX_CYC + 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SCAN   = 3'd1;
    localparam logic [2:0] ST_FILL   = 3'd2;
    localparam logic [2:0] ST_SETTLE = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    logic [2:0]            state;
    logic [N_CHAMBERS-1:0] pending;
    logic [TMR_W-1:0]      timer;
    logic                  pressure_q;
    logic                  aborted_q;
    logic [IDX_W-1:0]      lowest_idx;

    // Lowest set bit of the pending mask; scanning downward lets the lowest
    // index overwrite any higher one, which gives ascending fill order.
    always_comb begin
        lowest_idx = '0;
        for (int i = N_CHAMBERS - 1; i >= 0; i--) begin
            if (pending[i]) begin
                lowest_idx = IDX_W'(i);
            end
        end
    end

    // Main sequencer. pressure_ok is registered before use so the pump and
    // metering never see a raw pneumatic-side input combinationally.
    // Abort outranks everything (including the FILL terminal count) outside IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            pending      <= '0;
            timer        <= '0;
            cur_idx      <= '0;
            filled_count <= '0;
            pressure_q   <= 1'b0;
            aborted_q    <= 1'b0;
        end else begin
            pressure_q <= pressure_ok;
            aborted_q  <= 1'b0;
            if (abort && (state != ST_IDLE)) begin
                state     <= ST_IDLE;
                pending   <= '0;
                aborted_q <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start_if.start_valid) begin
                            pending      <= start_if.chamber_mask;
                            filled_count <= '0;
                            state        <= (start_if.chamber_mask == '0) ? ST_DONE : ST_SCAN;
                        end
                    end
                    ST_SCAN: begin
                        cur_idx <= lowest_idx;
                        timer   <= TMR_W'(FILL_CYCLES - 1);
                        state   <= ST_FILL;
                    end
                    ST_FILL: begin
                        // Pressure-low cycles neither count nor end the fill.
                        if (pressure_q) begin
                            if (timer == '0) begin
                                pending[cur_idx] <= 1'b0;
                                filled_count     <= filled_count + CNT_W'(1);
                                timer            <= TMR_W'(SETTLE_CYCLES - 1);
                                state            <= ST_SETTLE;
                            end else begin
                                timer <= timer - TMR_W'(1);
                            end
                        end
                    end
                    ST_SETTLE: begin
                        if (timer == '0) begin
                            state <= (pending != '0) ? ST_SCAN : ST_DONE;
                        end else begin
                            timer <= timer - TMR_W'(1);
                        end
                    end
                    ST_DONE: begin
                        state <= ST_IDLE;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // Output decode from registered state only, so an asynchronous reset
    // closes every valve and stops the pump immediately.
    assign start_if.start_ready = (state == ST_IDLE);
    assign busy                 = (state != ST_IDLE);
    assign done                 = (state == ST_DONE);
    assign aborted              = aborted_q;
    assign source_on            = (state == ST_FILL) && pressure_q;
    assign valve_en             = (state == ST_FILL)
                                  ? ({{(N_CHAMBERS-1){1'b0}}, 1'b1} << cur_idx)
                                  : '0;

endmodule
